image_loader: RTL and testbench
===============================

Name: image_loader

Overview:
- Producer side of the control unit's image/label input handshake.
- Accepts a word-serial stream (one label word, then NUM_PIX pixel words) from the host/memory interface and assembles it into a parallel image register.
- When the image is complete, presents image and label with start held high until the control unit returns ack.
- Sits directly upstream of control_unit in the deep top level and drives its start, label_in and image inputs.

Parameters:
NUM_PIX, 784, pixels per image; also the number of words in image_out.
PIX_W, 32, bits per pixel word and per stream word.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  asynchronous reset, active-low; clears all state immediately when low.
in_valid  input  1  stream word on in_data is valid.
in_data  input  PIX_W  stream word; for a label word only bits [7:0] are used.
in_sof  input  1  start-of-frame; marks the word as a label word.
in_ready  output  1  loader can accept a stream word this cycle.
start  output  1  complete image/label present; held until ack.
image_out  output  NUM_PIX x PIX_W  assembled image; word i = i-th pixel received.
label_out  output  8  label of the current frame.
ack  input  1  control unit has consumed image_out/label_out.
frames_done  output  16  count of frames acknowledged; wraps modulo 2^16.

Behaviour:
- Transfer rule: a word is transferred on a rising edge where in_valid && in_ready.
- Reset (rst low, async):
  - state = WAIT_LABEL, pixel index = 0, start = 0, in_ready = 0 while rst is low.
  - image_out = 0, label_out = 0, frames_done = 0.
- After rst deasserts, in_ready follows the state rules below.

- State WAIT_LABEL:
  - in_ready = 1.
  - On a transfer with in_sof = 1: label_out <= in_data[7:0], index <= 0, go to LOAD_PIX.
  - On a transfer with in_sof = 0: discard the word (pre-frame garbage); stay in WAIT_LABEL.

- State LOAD_PIX:
  - in_ready = 1.
  - On a transfer with in_sof = 0: image_out[index] <= in_data, index <= index + 1.
    - If index == NUM_PIX-1: index <= 0, go to PRESENT.
  - On a transfer with in_sof = 1 (resync): treat the word as a new label.
    - label_out <= in_data[7:0], index <= 0, stay in LOAD_PIX.
    - Previously written pixels are not cleared; they are overwritten as the new frame loads.

- State PRESENT:
  - in_ready = 0, start = 1.
  - image_out and label_out are held bit-stable.
  - On an edge with ack = 1: start <= 0, frames_done <= frames_done + 1, go to WAIT_LABEL.
  - ack may be high on the first PRESENT cycle; it is honoured.

- Latency:
  - start rises on the edge that accepts the last pixel, i.e. it is visible the cycle after that pixel's handshake.
  - Minimum frame period = 1 + NUM_PIX + 1 cycles (label + pixels + ack cycle).

- Boundary conditions:
  - ack outside PRESENT is ignored, with no effect on any state.
  - in_valid with in_ready = 0 is not consumed; the source must hold the word.
  - A reset mid-frame or mid-PRESENT aborts immediately: start drops asynchronously, and the partial frame is lost.
  - start is registered; it never depends combinationally on ack.
  - The index counter is $clog2(NUM_PIX) bits and never reaches NUM_PIX.
  - frames_done wraps 0xFFFF -> 0x0000.

Test Plan:
- Basic frame (NUM_PIX = 4): reset, then send label 0x07 with sof, followed by pixels 0x11, 0x22, 0x33, 0x44 on consecutive cycles.
  -> start = 1 the cycle after 0x44 is accepted; image_out = {0x11, 0x22, 0x33, 0x44}; label_out = 0x07; in_ready = 0.
- Delayed ack: hold ack low 10 cycles after start rises, with in_valid held high.
  -> start stays 1; no words consumed; outputs stable. Pulse ack for 1 cycle.
  -> start = 0 next cycle; frames_done = 1; in_ready = 1.
- Resync: label 0x03, pixels 0xA, 0xB, then sof with label 0x05, then pixels 1, 2, 3, 4.
  -> start rises after pixel 4; label_out = 0x05; image_out = {1, 2, 3, 4}.
- Garbage and stray ack: send 3 non-sof words and pulse ack in WAIT_LABEL.
  -> words discarded, frames_done = 0; the following sof frame loads normally.
- Mid-frame reset: drive rst low asynchronously (between clock edges) after label and 2 pixels.
  -> start = 0, image_out = 0, label_out = 0 immediately. After release, a full frame produces correct outputs.
- Default size plus counter wrap (NUM_PIX = 784): one full frame gives start after exactly 785 accepted words. Then preload frames_done = 0xFFFF via back-to-back frames (or force), acknowledge one more frame.
  -> frames_done = 0x0000.

Source files
------------

// File: rtl/image_loader.sv
// Word-serial image loader: one label word (sof) then NUM_PIX pixel words are
// assembled into image_out, then start is held until the consumer returns ack.
module image_loader #(
  parameter int NUM_PIX = 784,
  parameter int PIX_W   = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  input  logic [PIX_W-1:0]                in_data,
  input  logic                            in_sof,
  output logic                            in_ready,
  output logic                            start,
  output logic [NUM_PIX-1:0][PIX_W-1:0]   image_out,
  output logic [7:0]                      label_out,
  input  logic                            ack,
  output logic [15:0]                     frames_done,
  output logic [1:0]                      dbg_state
);

  localparam int IW = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_PIX - 1);

  typedef enum logic [1:0] {
    WAIT_LABEL = 2'd0,
    LOAD_PIX   = 2'd1,
    PRESENT    = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] idx;
  logic          xfer;

  // Handshake: a stream word moves on a rising edge where in_valid && in_ready;
  // the source holds the word while in_ready is low. start/ack is a level
  // request: start stays high until an edge samples ack high.
  assign xfer      = in_valid && in_ready;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= WAIT_LABEL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      WAIT_LABEL: begin
        in_ready = rst;
        if (xfer && in_sof) state_nxt = LOAD_PIX;
      end
      LOAD_PIX: begin
        in_ready = rst;
        if (xfer && !in_sof && idx == LAST_IDX) state_nxt = PRESENT;
      end
      PRESENT: begin
        if (ack) state_nxt = WAIT_LABEL;
      end
      default: state_nxt = WAIT_LABEL;
    endcase
  end

  // start is a flop so it never follows ack combinationally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start       <= 1'b0;
      idx         <= '0;
      label_out   <= '0;
      image_out   <= '0;
      frames_done <= '0;
    end else begin
      start <= (state_nxt == PRESENT);
      if (xfer) begin
        if (in_sof) begin
          // A sof mid-load resyncs: old pixels stay until overwritten.
          label_out <= in_data[7:0];
          idx       <= '0;
        end else if (state == LOAD_PIX) begin
          image_out[idx] <= in_data;
          idx            <= (idx == LAST_IDX) ? '0 : idx + IW'(1);
        end
      end
      if (state == PRESENT && ack) begin
        frames_done <= frames_done + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_image_loader.sv
// Bench for image_loader: a 4-pixel instance driven against a small reference
// model with a frame scoreboard, plus a default-size 784-pixel instance.
module tb_image_loader;

  localparam int SP = 4;
  localparam int LP = 784;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // small instance
  logic                  s_valid = 1'b0;
  logic                  s_sof   = 1'b0;
  logic                  s_ack   = 1'b0;
  logic [31:0]           s_data  = '0;
  logic                  s_ready;
  logic                  s_start;
  logic [SP-1:0][31:0]   s_image;
  logic [7:0]            s_label;
  logic [15:0]           s_frames;
  logic [1:0]            s_dbg;

  // default-size instance
  logic                  l_valid = 1'b0;
  logic                  l_sof   = 1'b0;
  logic                  l_ack   = 1'b0;
  logic [31:0]           l_data  = '0;
  logic                  l_ready;
  logic                  l_start;
  logic [LP-1:0][31:0]   l_image;
  logic [7:0]            l_label;
  logic [15:0]           l_frames;
  logic [1:0]            l_dbg;

  image_loader #(.NUM_PIX(SP), .PIX_W(32)) dut_s (
    .clk(clk), .rst(rst), .in_valid(s_valid), .in_data(s_data), .in_sof(s_sof),
    .in_ready(s_ready), .start(s_start), .image_out(s_image), .label_out(s_label),
    .ack(s_ack), .frames_done(s_frames), .dbg_state(s_dbg)
  );

  image_loader dut_l (
    .clk(clk), .rst(rst), .in_valid(l_valid), .in_data(l_data), .in_sof(l_sof),
    .in_ready(l_ready), .start(l_start), .image_out(l_image), .label_out(l_label),
    .ack(l_ack), .frames_done(l_frames), .dbg_state(l_dbg)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] l_exp_q[$];

  // reference model of the small instance: 0 wait label, 1 load, 2 present
  int          m_state  = 0;
  int          m_idx    = 0;
  logic [7:0]  m_label  = '0;
  logic [31:0] m_pix[SP];
  logic [15:0] m_frames = '0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic model_xfer(input logic [31:0] d, input logic sof);
    if (sof) begin
      m_label = d[7:0];
      m_idx   = 0;
      m_state = 1;
    end else if (m_state == 1) begin
      m_pix[m_idx] = d;
      if (m_idx == SP - 1) begin
        m_idx   = 0;
        m_state = 2;
        exp_q.push_back({24'b0, m_label});
        for (int i = 0; i < SP; i++) exp_q.push_back(m_pix[i]);
      end else begin
        m_idx++;
      end
    end
  endtask

  task automatic check_frame();
    logic [31:0] e;
    if (exp_q.size() < SP + 1) begin
      check("sb_underflow", 32'(exp_q.size()), 32'(SP + 1));
    end else begin
      e = exp_q.pop_front();
      check("frame_label", {24'b0, s_label}, e);
      for (int i = 0; i < SP; i++) begin
        e = exp_q.pop_front();
        check($sformatf("frame_pix%0d", i), s_image[i], e);
      end
    end
  endtask

  // called at a negedge; returns at the negedge after the transfer edge
  task automatic send_s(input logic [31:0] d, input logic sof);
    int prev;
    s_valid = 1'b1;
    s_data  = d;
    s_sof   = sof;
    check("s_ready_pre", 32'(s_ready), 32'(m_state != 2));
    prev = m_state;
    if (m_state != 2) model_xfer(d, sof);
    @(negedge clk);
    s_valid = 1'b0;
    s_sof   = 1'b0;
    check("s_start", 32'(s_start), 32'(m_state == 2));
    if (prev == 1 && m_state == 2) begin
      check("s_ready_present", 32'(s_ready), 32'd0);
      check_frame();
    end
  endtask

  task automatic ack_s();
    s_ack = 1'b1;
    if (m_state == 2) begin
      m_state = 0;
      m_frames++;
    end
    @(negedge clk);
    s_ack = 1'b0;
    check("ack_start", 32'(s_start), 32'(m_state == 2));
    check("ack_frames", {16'b0, s_frames}, {16'b0, m_frames});
    check("ack_ready", 32'(s_ready), 32'(m_state != 2));
  endtask

  task automatic send_rand_frame_s(input logic [7:0] lbl);
    send_s({24'b0, lbl}, 1'b1);
    for (int i = 0; i < SP; i++) send_s($urandom_range(0, 32'hFFFF_FFFE), 1'b0);
  endtask

  task automatic reset_model();
    m_state  = 0;
    m_idx    = 0;
    m_label  = '0;
    m_frames = '0;
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < SP; i++) m_pix[i] = '0;

    // reset state
    @(negedge clk);
    check("rst_start", 32'(s_start), 32'd0);
    check("rst_ready", 32'(s_ready), 32'd0);
    check("rst_label", {24'b0, s_label}, 32'd0);
    check("rst_frames", {16'b0, s_frames}, 32'd0);
    check("rst_image0", s_image[0], 32'd0);
    check("rst_l_ready", 32'(l_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(s_ready), 32'd1);

    // basic frame
    send_s(32'h07, 1'b1);
    send_s(32'h11, 1'b0);
    send_s(32'h22, 1'b0);
    send_s(32'h33, 1'b0);
    send_s(32'h44, 1'b0);

    // delayed ack with a word held on the input
    s_valid = 1'b1;
    s_data  = 32'hDEAD_BEEF;
    s_sof   = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("hold_start", 32'(s_start), 32'd1);
      check("hold_ready", 32'(s_ready), 32'd0);
      check("hold_label", {24'b0, s_label}, 32'h07);
      check("hold_pix3", s_image[3], 32'h44);
    end
    s_valid = 1'b0;
    s_sof   = 1'b0;
    ack_s();

    // resync mid-frame
    send_s(32'h03, 1'b1);
    send_s(32'h0A, 1'b0);
    send_s(32'h0B, 1'b0);
    send_s(32'h05, 1'b1);
    send_s(32'h01, 1'b0);
    send_s(32'h02, 1'b0);
    send_s(32'h03, 1'b0);
    send_s(32'h04, 1'b0);
    ack_s();

    // garbage words and a stray ack
    send_s(32'h99, 1'b0);
    send_s(32'h98, 1'b0);
    send_s(32'h97, 1'b0);
    ack_s();
    send_rand_frame_s(8'h42);
    ack_s();

    // mid-frame asynchronous reset
    send_s(32'h66, 1'b1);
    send_s(32'h55, 1'b0);
    send_s(32'h56, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("mrst_start", 32'(s_start), 32'd0);
    check("mrst_ready", 32'(s_ready), 32'd0);
    check("mrst_label", {24'b0, s_label}, 32'd0);
    check("mrst_pix0", s_image[0], 32'd0);
    check("mrst_pix1", s_image[1], 32'd0);
    check("mrst_frames", {16'b0, s_frames}, 32'd0);
    reset_model();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send_rand_frame_s(8'h21);

    // reset while presenting: start must drop without a clock edge
    #2 rst = 1'b0;
    #1;
    check("prst_start", 32'(s_start), 32'd0);
    check("prst_label", {24'b0, s_label}, 32'd0);
    reset_model();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // frames_done wrap
    force dut_s.frames_done = 16'hFFFF;
    @(negedge clk);
    release dut_s.frames_done;
    m_frames = 16'hFFFF;
    @(negedge clk);
    check("wrap_preload", {16'b0, s_frames}, 32'h0000_FFFF);
    send_rand_frame_s(8'hC3);
    ack_s();

    // default size: 785 accepted words to start
    l_valid = 1'b1;
    l_sof   = 1'b1;
    l_data  = 32'h0000_01A3;
    check("l_ready", 32'(l_ready), 32'd1);
    @(negedge clk);
    l_sof = 1'b0;
    for (int i = 0; i < LP; i++) begin
      l_data = $urandom();
      l_exp_q.push_back(l_data);
      if (i == LP - 1) check("l_start_early", 32'(l_start), 32'd0);
      @(negedge clk);
    end
    l_valid = 1'b0;
    check("l_start", 32'(l_start), 32'd1);
    check("l_ready_present", 32'(l_ready), 32'd0);
    check("l_label", {24'b0, l_label}, 32'hA3);
    for (int i = 0; i < LP; i++) begin
      if (l_exp_q.size() == 0) begin
        check("l_sb_underflow", 32'd0, 32'd1);
        break;
      end
      check($sformatf("l_pix%0d", i), l_image[i], l_exp_q.pop_front());
    end
    l_ack = 1'b1;
    @(negedge clk);
    l_ack = 1'b0;
    check("l_ack_start", 32'(l_start), 32'd0);
    check("l_frames", {16'b0, l_frames}, 32'd1);

    check("sb_leftover", 32'(exp_q.size()), 32'd0);
    check("l_sb_leftover", 32'(l_exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
